// File: rtl/csr_int_ctrl_if.sv
// Pipeline-side port bundle of the interrupt/trap sequencer.
// master: ID/EX stage and CSR file side; slave: csr_int_ctrl.
interface csr_int_ctrl_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 16
);
    // Trigger sources and EX-stage status
    logic          irq_i;
    logic          ecall_i;
    logic          mret_i;
    logic [AW-1:0] inst_addr_i;
    logic          ex_jump_i;
    logic [AW-1:0] ex_jump_addr_i;
    logic          ex_csr_we_i;
    logic          ex_busy_i;

    // CSR file read-back
    logic          global_int_en_i;
    logic [DW-1:0] csr_mtvec_i;
    logic [DW-1:0] csr_mepc_i;
    logic [DW-1:0] csr_mstatus_i;

    // Stall, CSR write port and PC redirect
    logic          hold_o;
    logic          csr_we_o;
    logic [AW-1:0] csr_waddr_o;
    logic [AW-1:0] csr_raddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic          jump_o;
    logic [AW-1:0] jump_addr_o;

    modport master (
        output irq_i, ecall_i, mret_i, inst_addr_i, ex_jump_i, ex_jump_addr_i,
               ex_csr_we_i, ex_busy_i, global_int_en_i, csr_mtvec_i, csr_mepc_i,
               csr_mstatus_i,
        input  hold_o, csr_we_o, csr_waddr_o, csr_raddr_o, csr_wdata_o, jump_o,
               jump_addr_o
    );

    modport slave (
        input  irq_i, ecall_i, mret_i, inst_addr_i, ex_jump_i, ex_jump_addr_i,
               ex_csr_we_i, ex_busy_i, global_int_en_i, csr_mtvec_i, csr_mepc_i,
               csr_mstatus_i,
        output hold_o, csr_we_o, csr_waddr_o, csr_raddr_o, csr_wdata_o, jump_o,
               jump_addr_o
    );
endinterface

// File: rtl/csr_int_ctrl.sv
// Interrupt/trap sequencer: stalls the pipeline, writes mepc/mcause/mstatus
// through the CSR "int" port one per cycle, then issues a one-cycle jump.
module csr_int_ctrl #(
    parameter int unsigned    DW          = 16,
    parameter int unsigned    AW          = 16,
    parameter logic [DW-1:0]  IRQ_CAUSE   = DW'(16'h800B),
    parameter logic [DW-1:0]  ECALL_CAUSE = DW'(16'h000B)
) (
    input  logic           clk,
    input  logic           rst,
    csr_int_ctrl_if.slave  bus
);

    localparam int unsigned CSR_AW   = 12;
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_W_MRET,
        S_JUMP
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   epc_q, epc_d;
    logic [DW-1:0]   cause_q, cause_d;
    logic            is_mret_q, is_mret_d;

    logic            csr_we_q, csr_we_d;
    logic [AW-1:0]   csr_waddr_q, csr_waddr_d;
    logic [DW-1:0]   csr_wdata_q, csr_wdata_d;
    logic            jump_q, jump_d;
    logic [AW-1:0]   jump_addr_q, jump_addr_d;

    logic            trigger;
    logic            ex_port_busy;
    logic [DW-1:0]   mstatus_trap;
    logic [DW-1:0]   mstatus_mret;

    // Next-state, capture and output decode. Outputs are decoded from the
    // next state so the registered write appears in the cycle of that state.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        is_mret_d    = is_mret_q;
        csr_we_d     = 1'b0;
        csr_waddr_d  = '0;
        csr_wdata_d  = '0;
        jump_d       = 1'b0;
        jump_addr_d  = '0;

        trigger      = bus.ecall_i | bus.mret_i | (bus.irq_i & bus.global_int_en_i);
        ex_port_busy = bus.ex_csr_we_i | bus.ex_busy_i;

        mstatus_trap           = bus.csr_mstatus_i;
        mstatus_trap[MPIE_BIT] = bus.csr_mstatus_i[MIE_BIT];
        mstatus_trap[MIE_BIT]  = 1'b0;

        mstatus_mret           = bus.csr_mstatus_i;
        mstatus_mret[MIE_BIT]  = bus.csr_mstatus_i[MPIE_BIT];
        mstatus_mret[MPIE_BIT] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    epc_d     = bus.ex_jump_i ? bus.ex_jump_addr_i : bus.inst_addr_i;
                    is_mret_d = bus.mret_i & ~bus.ecall_i;
                    if (!is_mret_d) begin
                        cause_d = bus.ecall_i ? ECALL_CAUSE : IRQ_CAUSE;
                    end
                    if (ex_port_busy) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = is_mret_d ? S_W_MRET : S_W_MEPC;
                    end
                end
            end
            // The EX write port has priority in the CSR file; never overlap it.
            S_WAIT: begin
                if (!ex_port_busy) begin
                    state_d = is_mret_q ? S_W_MRET : S_W_MEPC;
                end
            end
            S_W_MEPC:    state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_JUMP;
            S_W_MRET:    state_d = S_JUMP;
            S_JUMP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        case (state_d)
            S_W_MEPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = AW'(CSR_MEPC);
                csr_wdata_d = DW'(epc_d);
            end
            S_W_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = AW'(CSR_MCAUSE);
                csr_wdata_d = cause_d;
            end
            S_W_MSTATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = AW'(CSR_MSTATUS);
                csr_wdata_d = mstatus_trap;
            end
            S_W_MRET: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = AW'(CSR_MSTATUS);
                csr_wdata_d = mstatus_mret;
            end
            S_JUMP: begin
                jump_d      = 1'b1;
                jump_addr_d = is_mret_d ? AW'(bus.csr_mepc_i) : AW'(bus.csr_mtvec_i);
            end
            default: begin
                csr_we_d = 1'b0;
            end
        endcase
    end

    // State, captured context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            epc_q       <= '0;
            cause_q     <= '0;
            is_mret_q   <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            is_mret_q   <= is_mret_d;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            jump_q      <= jump_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    // Stall must reach IF/ID/EX in the trigger cycle itself
    assign bus.hold_o      = (state_q != S_IDLE) | trigger;
    assign bus.csr_raddr_o = AW'(CSR_MSTATUS);
    assign bus.csr_we_o    = csr_we_q;
    assign bus.csr_waddr_o = csr_waddr_q;
    assign bus.csr_wdata_o = csr_wdata_q;
    assign bus.jump_o      = jump_q;
    assign bus.jump_addr_o = jump_addr_q;

endmodule

// File: tb/tb_csr_int_ctrl.sv
// Self-checking bench for csr_int_ctrl: vector table plus hand-written
// WAIT and mid-sequence reset cases, checked cycle by cycle via a scoreboard.
module tb_csr_int_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_int_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    csr_int_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum int {K_TRAP, K_MRET, K_NONE} kind_e;

    typedef struct {
        logic        hold;
        logic        we;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        jump;
        logic [15:0] jaddr;
        string       tag;
    } exp_t;

    typedef struct {
        string       name;
        logic        irq, ecall, mret, mie, exj;
        logic [15:0] mstatus, inst, exja, mtvec, mepc;
        kind_e       kind;
        logic [15:0] e_epc, e_cause, e_mst, e_jaddr;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[9];

    function automatic void push(logic hold, logic we, logic [15:0] waddr,
                                 logic [15:0] wdata, logic jump, logic [15:0] jaddr,
                                 string tag);
        exp_t e;
        e.hold = hold; e.we = we; e.waddr = waddr; e.wdata = wdata;
        e.jump = jump; e.jaddr = jaddr; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic vec_t mk(string name, logic irq, logic ecall, logic mret, logic mie,
                                logic [15:0] mstatus, logic [15:0] inst, logic exj,
                                logic [15:0] exja, logic [15:0] mtvec, logic [15:0] mepc,
                                kind_e kind, logic [15:0] e_epc, logic [15:0] e_cause,
                                logic [15:0] e_mst, logic [15:0] e_jaddr);
        vec_t v;
        v.name = name; v.irq = irq; v.ecall = ecall; v.mret = mret; v.mie = mie;
        v.mstatus = mstatus; v.inst = inst; v.exj = exj; v.exja = exja;
        v.mtvec = mtvec; v.mepc = mepc; v.kind = kind; v.e_epc = e_epc;
        v.e_cause = e_cause; v.e_mst = e_mst; v.e_jaddr = e_jaddr;
        return v;
    endfunction

    // Expected per-cycle outputs from the trigger cycle up to the first idle cycle
    function automatic void push_seq(vec_t v, int wait_cyc);
        if (v.kind == K_NONE) begin
            push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, {v.name, ":trig"});
            push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, {v.name, ":quiet1"});
            push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, {v.name, ":quiet2"});
            return;
        end
        push(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, {v.name, ":trig"});
        for (int i = 0; i < wait_cyc; i++)
            push(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, {v.name, ":wait"});
        if (v.kind == K_TRAP) begin
            push(1'b1, 1'b1, 16'h0341, v.e_epc,   1'b0, 16'h0, {v.name, ":mepc"});
            push(1'b1, 1'b1, 16'h0342, v.e_cause, 1'b0, 16'h0, {v.name, ":mcause"});
            push(1'b1, 1'b1, 16'h0300, v.e_mst,   1'b0, 16'h0, {v.name, ":mstatus"});
        end else begin
            push(1'b1, 1'b1, 16'h0300, v.e_mst,   1'b0, 16'h0, {v.name, ":mret_wr"});
        end
        push(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, v.e_jaddr, {v.name, ":jump"});
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,     {v.name, ":idle"});
    endfunction

    task automatic check();
        exp_t e;
        logic ok;
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow: no expected record at t=%0t", $time);
            return;
        end
        e = sb.pop_front();
        ok = (bus.hold_o === e.hold) && (bus.csr_we_o === e.we) && (bus.jump_o === e.jump);
        if (e.we)   ok = ok && (bus.csr_waddr_o === e.waddr) && (bus.csr_wdata_o === e.wdata);
        if (e.jump) ok = ok && (bus.jump_addr_o === e.jaddr);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got hold=%b we=%b waddr=%h wdata=%h jump=%b jaddr=%h, want hold=%b we=%b waddr=%h wdata=%h jump=%b jaddr=%h",
                     e.tag, bus.hold_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o,
                     bus.jump_o, bus.jump_addr_o, e.hold, e.we, e.waddr, e.wdata,
                     e.jump, e.jaddr);
        end
    endtask

    task automatic idle_inputs();
        bus.irq_i = 1'b0; bus.ecall_i = 1'b0; bus.mret_i = 1'b0;
        bus.inst_addr_i = '0; bus.ex_jump_i = 1'b0; bus.ex_jump_addr_i = '0;
        bus.ex_csr_we_i = 1'b0; bus.ex_busy_i = 1'b0; bus.global_int_en_i = 1'b0;
        bus.csr_mtvec_i = '0; bus.csr_mepc_i = '0; bus.csr_mstatus_i = '0;
    endtask

    // Apply one trigger; EX write port / busy held for we_cyc / busy_cyc cycles
    task automatic run_vec(vec_t v, int we_cyc, int busy_cyc);
        int wait_cyc;
        int guard;
        wait_cyc = (we_cyc > busy_cyc) ? we_cyc : busy_cyc;
        guard = 0;
        for (int c = 0; (c == 0) || (sb.size() > 0); c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.irq_i = v.irq; bus.ecall_i = v.ecall; bus.mret_i = v.mret;
                bus.global_int_en_i = v.mie; bus.csr_mstatus_i = v.mstatus;
                bus.inst_addr_i = v.inst; bus.ex_jump_i = v.exj; bus.ex_jump_addr_i = v.exja;
                bus.csr_mtvec_i = v.mtvec; bus.csr_mepc_i = v.mepc;
                push_seq(v, wait_cyc);
            end else begin
                bus.ecall_i = 1'b0; bus.mret_i = 1'b0; bus.ex_jump_i = 1'b0;
                if (v.kind != K_NONE) bus.irq_i = 1'b0;
            end
            bus.ex_csr_we_i = (c < we_cyc);
            bus.ex_busy_i   = (c < busy_cyc);
            check();
            guard++;
            if (guard > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_timeout: %0d records left, want 0", v.name, sb.size());
                sb.delete();
            end
        end
        bus.irq_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        push(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, "reset_state");
        @(negedge clk);
        check();
        rst = 1'b0;

        vecs[0] = mk("irq_basic",   1,0,0,1, 16'h0008, 16'h0040, 0, 16'h0000, 16'h0100, 16'h0000,
                     K_TRAP, 16'h0040, 16'h800B, 16'h0080, 16'h0100);
        vecs[1] = mk("ecall_irq",   1,1,0,1, 16'h0008, 16'h0022, 0, 16'h0000, 16'h0100, 16'h0000,
                     K_TRAP, 16'h0022, 16'h000B, 16'h0080, 16'h0100);
        vecs[2] = mk("irq_masked",  1,0,0,0, 16'h0080, 16'h0030, 0, 16'h0000, 16'h0100, 16'h0000,
                     K_NONE, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        vecs[3] = mk("mret_basic",  0,0,1,0, 16'h0080, 16'h0060, 0, 16'h0000, 16'h0100, 16'h0044,
                     K_MRET, 16'h0000, 16'h0000, 16'h0088, 16'h0044);
        vecs[4] = mk("irq_exjump",  1,0,0,1, 16'h0008, 16'h0050, 1, 16'h0200, 16'h0100, 16'h0000,
                     K_TRAP, 16'h0200, 16'h800B, 16'h0080, 16'h0100);
        vecs[5] = mk("ecall_mie0",  0,1,0,0, 16'h0000, 16'h1234, 0, 16'h0000, 16'h0300, 16'h0000,
                     K_TRAP, 16'h1234, 16'h000B, 16'h0000, 16'h0300);
        vecs[6] = mk("mret_mpie0",  0,0,1,0, 16'h0008, 16'h0070, 0, 16'h0000, 16'h0100, 16'h0ABC,
                     K_MRET, 16'h0000, 16'h0000, 16'h0080, 16'h0ABC);
        vecs[7] = mk("mret_irq",    1,0,1,1, 16'h0080, 16'h0074, 0, 16'h0000, 16'h0100, 16'h0044,
                     K_MRET, 16'h0000, 16'h0000, 16'h0088, 16'h0044);
        vecs[8] = mk("ecall_mret",  0,1,1,1, 16'hFFFF, 16'h0ABE, 1, 16'h0B00, 16'hC000, 16'h0044,
                     K_TRAP, 16'h0B00, 16'h000B, 16'hFFF7, 16'hC000);

        foreach (vecs[i]) run_vec(vecs[i], 0, 0);

        // After trap entry MIE=0: a still-pending irq must not be taken
        v = vecs[2];
        v.name = "irq_after_entry";
        run_vec(v, 0, 0);

        // EX CSR write in flight for two cycles: two WAIT cycles before mepc
        v = vecs[0];
        v.name = "irq_wait_we";
        run_vec(v, 2, 0);

        // Multi-cycle EX op on mret: one WAIT cycle
        v = vecs[3];
        v.name = "mret_wait_busy";
        run_vec(v, 0, 1);

        // Reset asserted for two cycles while mcause is being written
        @(negedge clk);
        bus.irq_i = 1'b1; bus.global_int_en_i = 1'b1; bus.csr_mstatus_i = 16'h0008;
        bus.inst_addr_i = 16'h0040; bus.csr_mtvec_i = 16'h0100;
        push(1'b1, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:trig");
        push(1'b1, 1'b1, 16'h0341, 16'h0040, 1'b0, 16'h0, "rst_seq:mepc");
        push(1'b1, 1'b1, 16'h0342, 16'h800B, 1'b0, 16'h0, "rst_seq:mcause");
        push(1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:rst1");
        push(1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:rst2");
        push(1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:post1");
        push(1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:post2");
        push(1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0, "rst_seq:post3");
        check();
        @(negedge clk); bus.irq_i = 1'b0; check();
        @(negedge clk); rst = 1'b1; check();
        @(negedge clk); check();
        @(negedge clk); rst = 1'b0; check();
        repeat (3) begin
            @(negedge clk);
            check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/csr_int_ctrl.md
Name: csr_int_ctrl

Overview:
- Interrupt/trap sequencer that owns the CSR file's "int" write/read port.
- On an external interrupt, ecall or mret, it stalls the pipeline and writes mepc, mcause and mstatus one per cycle. It then issues a single-cycle jump to mtvec, or to mepc for mret.
- Sits between ID/EX and the CSR file; the only driver of csr_we/csr_waddr/csr_wdata.

Parameters:
- DW, 16, data width (matches DATABUS)
- AW, 16, address width (matches ADDRBUS); CSR number in [11:0]
- IRQ_CAUSE, 16'h800B, mcause for external interrupt
- ECALL_CAUSE, 16'h000B, mcause for ecall

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- irq_i  in  1  external interrupt request, level
- ecall_i  in  1  ecall decoded in EX this cycle
- mret_i  in  1  mret decoded in EX this cycle
- inst_addr_i  in  AW  PC of the instruction currently in EX
- ex_jump_i  in  1  EX is redirecting the PC this cycle
- ex_jump_addr_i  in  AW  EX redirect target
- ex_csr_we_i  in  1  EX is writing a CSR this cycle
- ex_busy_i  in  1  multi-cycle EX op in progress
- global_int_en_i  in  1  mstatus.MIE from the CSR file
- csr_mtvec_i  in  DW  mtvec
- csr_mepc_i  in  DW  mepc
- csr_mstatus_i  in  DW  mstatus
- hold_o  out  1  stall IF/ID/EX
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  AW  CSR write address
- csr_raddr_o  out  AW  CSR read address, tied to 12'h300
- csr_wdata_o  out  DW  CSR write data
- jump_o  out  1  PC redirect, one cycle
- jump_addr_o  out  AW  redirect target

Behaviour:
- States: IDLE, WAIT, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, JUMP.
- Reset (sync, rst=1 at posedge): state=IDLE. All registered outputs become 0 at that edge: csr_we_o, csr_waddr_o, csr_wdata_o, jump_o, jump_addr_o. Any sequence in flight is abandoned; no partial write is issued after the reset edge.
- Trigger priority in IDLE: ecall_i > mret_i > (irq_i & global_int_en_i).
  - ecall and irq load cause_r with ECALL_CAUSE / IRQ_CAUSE respectively.
  - Interrupts are never taken outside IDLE. irq_i is not latched; it must still be high when sampled in IDLE.
- Captured return PC (epc_r), at the trigger edge:
  - If ex_jump_i=1: epc_r = ex_jump_addr_i.
  - Otherwise: epc_r = inst_addr_i. For ecall, software adds 4.
- hold_o is combinational: 1 when state!=IDLE, or when in IDLE with a trigger present. It deasserts in the cycle after JUMP.
- Entering the sequence:
  - If ex_csr_we_i or ex_busy_i is high at the trigger, go to WAIT. Leave WAIT when both are low. This guarantees the EX port, which has priority in the CSR file, never masks an int write.
  - Otherwise go directly to W_MEPC (trap/irq) or W_MRET (mret).
- Trap/irq writes, one per state:
  - W_MEPC: csr_we_o=1, waddr=12'h341, wdata=epc_r.
  - W_MCAUSE: csr_we_o=1, waddr=12'h342, wdata=cause_r.
  - W_MSTATUS: csr_we_o=1, waddr=12'h300, wdata=mstatus with bit7 (MPIE) set to old bit3 and bit3 (MIE) cleared. All other bits are taken unchanged from csr_mstatus_i.
  - Then JUMP with jump_addr_o=csr_mtvec_i.
- mret write:
  - W_MRET: csr_we_o=1, waddr=12'h300, wdata=mstatus with bit3 set to old bit7 and bit7 set to 1.
  - Then JUMP with jump_addr_o=csr_mepc_i.
- JUMP: jump_o=1 for exactly one cycle, csr_we_o=0, then return to IDLE.
- Latency (trigger cycle N, no WAIT):
  - Trap: writes in N+1, N+2, N+3; jump_o in N+4.
  - mret: write in N+1; jump_o in N+2.
- Simultaneous ecall and irq: ecall is served and irq is ignored. After the handler entry MIE=0, so the irq is masked.
- All outputs are registered except hold_o. csr_waddr_o is zero-extended to AW.

Test Plan:
- Reset: rst=1 for 2 cycles during W_MCAUSE -> next cycle state IDLE, csr_we_o=0, jump_o=0, hold_o=0; no further writes.
- irq_i=1, MIE=1, mstatus=16'h0008, inst_addr_i=16'h0040, mtvec=16'h0100 -> writes 341<=0040 (N+1), 342<=800B (N+2), 300<=0080 (N+3); jump_o=1 to 0100 at N+4; hold_o high N..N+4.
- ecall_i=1 and irq_i=1 together, inst_addr_i=16'h0022 -> mcause written 000B, mepc 0022; irq not re-taken after return while MIE=0.
- mret_i=1, mstatus=16'h0080, mepc=16'h0044 -> N+1 writes 300<=0088; N+2 jump_o=1 to 0044.
- irq with ex_csr_we_i=1 for 2 cycles -> WAIT for 2 cycles, then W_MEPC; 341 write never coincides with ex_csr_we_i=1.
- irq with ex_jump_i=1, ex_jump_addr_i=16'h0200 -> mepc written 0200. irq_i with MIE=0 -> no activity, hold_o=0.
